// File: rtl/instfetch_arb.sv
// instfetch_arb: round-robin arbiter sharing one instruction memory
// between N_REQ requesters, one fetch in flight (IDLE->FETCH->RESP).
// Ports: clk, rst_n (sync, active-low); req/req_addr/req_ack grant side;
// rsp_valid/rsp_ready/rsp_inst response side; mem_addr/mem_inst memory;
// busy is high whenever a transaction is in flight.
`ifndef INSTMEM_ADDR_WIDTH
`define INSTMEM_ADDR_WIDTH 8
`endif
`ifndef INST_LENGTH
`define INST_LENGTH 32
`endif

module instfetch_arb #(
  parameter int N_REQ  = 4,
  parameter int ADDR_W = `INSTMEM_ADDR_WIDTH,
  parameter int INST_W = `INST_LENGTH
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [N_REQ-1:0]        req,
  input  logic [N_REQ*ADDR_W-1:0] req_addr,
  output logic [N_REQ-1:0]        req_ack,
  output logic [N_REQ-1:0]        rsp_valid,
  input  logic [N_REQ-1:0]        rsp_ready,
  output logic [INST_W-1:0]       rsp_inst,
  output logic [ADDR_W-1:0]       mem_addr,
  input  logic [INST_W-1:0]       mem_inst,
  output logic                    busy
);

  localparam int PW = $clog2(N_REQ);

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    RESP
  } state_e;

  state_e             state_q;
  logic [PW-1:0]      ptr_q;
  logic [PW-1:0]      gnt_q;
  logic [ADDR_W-1:0]  addr_q;
  logic [INST_W-1:0]  inst_q;
  logic [N_REQ-1:0]   vld_q;

  logic [PW-1:0]      gnt_d;
  logic [PW-1:0]      ptr_d;
  logic               hit;
  logic [PW-1:0]      sel;
  int                 idx;

  // First requesting index at or after ptr_q, wrapping modulo N_REQ.
  always_comb begin
    gnt_d = '0;
    hit   = 1'b0;
    sel   = '0;
    idx   = 0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = int'(ptr_q) + k;
      if (idx >= N_REQ) idx = idx - N_REQ;
      sel = PW'(idx);
      if (!hit && req[sel]) begin
        hit   = 1'b1;
        gnt_d = sel;
      end
    end
  end

  always_comb begin
    ptr_d = gnt_d + PW'(1);
    if (int'(gnt_d) == N_REQ - 1) ptr_d = '0;
  end

  // Ack is a same-cycle pulse in IDLE; suppressed while reset is held.
  always_comb begin
    req_ack = '0;
    if (rst_n && state_q == IDLE && hit) req_ack[gnt_d] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      gnt_q   <= '0;
      addr_q  <= '0;
      inst_q  <= '0;
      vld_q   <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (hit) begin
            gnt_q   <= gnt_d;
            ptr_q   <= ptr_d;
            addr_q  <= req_addr[int'(gnt_d)*ADDR_W +: ADDR_W];
            state_q <= FETCH;
          end
        end
        FETCH: begin
          inst_q  <= mem_inst;
          vld_q   <= {{(N_REQ-1){1'b0}}, 1'b1} << gnt_q;
          state_q <= RESP;
        end
        RESP: begin
          if (rsp_ready[gnt_q]) begin
            vld_q   <= '0;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign mem_addr  = addr_q;
  assign rsp_inst  = inst_q;
  assign rsp_valid = vld_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_instfetch_arb.sv
// tb_instfetch_arb: directed + randomized checks of instfetch_arb
// against a transaction-level reference model.
module tb_instfetch_arb;

  localparam int N  = 4;
  localparam int AW = 8;
  localparam int IW = 32;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [N-1:0]  req;
  logic [N*AW-1:0] req_addr;
  logic [N-1:0]  req_ack;
  logic [N-1:0]  rsp_valid;
  logic [N-1:0]  rsp_ready;
  logic [IW-1:0] rsp_inst;
  logic [AW-1:0] mem_addr;
  logic [IW-1:0] mem_inst;
  logic          busy;

  logic [IW-1:0] mem [0:255];
  assign mem_inst = mem[mem_addr];

  always #5 clk = ~clk;

  instfetch_arb #(
    .N_REQ (N),
    .ADDR_W(AW),
    .INST_W(IW)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req      (req),
    .req_addr (req_addr),
    .req_ack  (req_ack),
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .rsp_inst (rsp_inst),
    .mem_addr (mem_addr),
    .mem_inst (mem_inst),
    .busy     (busy)
  );

  int n_chk  = 0;
  int n_fail = 0;

  // Reference model: one outstanding transaction record.
  bit            m_act;
  int            m_own;
  int            m_age;
  int            m_ptr;
  logic [AW-1:0] m_addr;
  logic [IW-1:0] m_inst;
  int            cycle;
  int            acks[$];
  int            ackcyc[$];

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int rr(input logic [N-1:0] r, input int p);
    logic [N-1:0] rv;
    rv = r;
    for (int k = 0; k < N; k++)
      if (rv[(p + k) % N]) return (p + k) % N;
    return -1;
  endfunction

  // Called just after a negedge with inputs already driven.
  task automatic cyc();
    logic [N-1:0] ack_e;
    logic [N-1:0] vld_e;
    int w;
    #1;
    w = rr(req, m_ptr);
    ack_e = '0;
    vld_e = '0;
    if (!m_act && rst_n && w >= 0) ack_e[w] = 1'b1;
    if (m_act && m_age >= 2) vld_e[m_own] = 1'b1;
    chk("req_ack", 64'(req_ack), 64'(ack_e));
    chk("rsp_valid", 64'(rsp_valid), 64'(vld_e));
    chk("rsp_inst", 64'(rsp_inst), 64'(m_inst));
    chk("mem_addr", 64'(mem_addr), 64'(m_addr));
    chk("busy", 64'(busy), 64'(m_act));
    @(posedge clk);
    if (!rst_n) begin
      m_act  = 0;
      m_ptr  = 0;
      m_age  = 0;
      m_addr = '0;
      m_inst = '0;
    end else if (!m_act) begin
      if (w >= 0) begin
        m_act  = 1;
        m_own  = w;
        m_age  = 1;
        m_addr = req_addr[w*AW +: AW];
        m_ptr  = (w + 1) % N;
        acks.push_back(w);
        ackcyc.push_back(cycle);
      end
    end else if (m_age == 1) begin
      m_inst = mem[m_addr];
      m_age  = 2;
    end else if (rsp_ready[m_own]) begin
      m_act = 0;
    end
    cycle++;
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req   = '0;
    cyc();
    rst_n = 1'b1;
  endtask

  logic [IW-1:0] held;
  int            n1;

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = $urandom;
    mem[5]    = 32'hA7;
    rst_n     = 1'b0;
    req       = '0;
    req_addr  = '0;
    rsp_ready = '0;
    m_act = 0; m_own = 0; m_age = 0; m_ptr = 0;
    m_addr = '0; m_inst = '0; cycle = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    cyc();
    cyc();
    rst_n = 1'b1;

    // Single request, fixed latency
    req = 4'b0001;
    req_addr[0 +: AW] = 8'h05;
    #1 chk("single_ack", 64'(req_ack), 64'h1);
    cyc();
    req = '0;
    #1 chk("single_addr", 64'(mem_addr), 64'h05);
    cyc();
    #1 chk("single_vld", 64'(rsp_valid), 64'h1);
    chk("single_inst", 64'(rsp_inst), 64'hA7);
    rsp_ready = 4'b0001;
    cyc();

    // All requesting, ready tied high: order and spacing
    do_reset();
    acks.delete();
    ackcyc.delete();
    req = 4'b1111;
    rsp_ready = 4'b1111;
    for (int i = 0; i < N; i++) req_addr[i*AW +: AW] = AW'($urandom);
    repeat (14) cyc();
    req = '0;
    repeat (3) cyc();
    chk("rr_count", 64'(acks.size()), 64'd5);
    for (int i = 0; i < 5 && i < acks.size(); i++) begin
      chk("rr_order", 64'(acks[i]), 64'(i % N));
      if (i > 0) chk("rr_space", 64'(ackcyc[i] - ackcyc[i-1]), 64'd3);
    end

    // Backpressure on requester 2, others ignored
    req = 4'b0100;
    rsp_ready = '0;
    cyc();
    cyc();
    held = rsp_inst;
    req = 4'b1111;
    rsp_ready = 4'b1011;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("bp_ack", 64'(req_ack), 64'h0);
      chk("bp_busy", 64'(busy), 64'h1);
      chk("bp_vld", 64'(rsp_valid), 64'h4);
      chk("bp_inst", 64'(rsp_inst), 64'(held));
      cyc();
    end
    req = '0;
    rsp_ready = 4'b1111;
    cyc();

    // Pointer fairness: bring p to 2, then req=0011 grants 0
    req = 4'b0010;
    cyc();
    req = '0;
    cyc();
    cyc();
    req = 4'b0011;
    #1 chk("ptr_grant0", 64'(req_ack), 64'h1);
    cyc();
    req = '0;
    cyc();
    cyc();
    req = 4'b0011;
    #1 chk("ptr_grant1", 64'(req_ack), 64'h2);
    cyc();
    req = '0;
    cyc();
    cyc();

    // Reset while in RESP
    req = 4'b0100;
    rsp_ready = '0;
    cyc();
    req = '0;
    cyc();
    #1 chk("rst_pre_vld", 64'(rsp_valid), 64'h4);
    rst_n = 1'b0;
    cyc();
    rst_n = 1'b1;
    #1 chk("rst_vld", 64'(rsp_valid), 64'h0);
    chk("rst_busy", 64'(busy), 64'h0);
    req = 4'b1111;
    #1 chk("rst_grant0", 64'(req_ack), 64'h1);
    cyc();
    req = '0;
    rsp_ready = 4'b1111;
    cyc();
    cyc();

    // Withdrawal of requester 1 while busy
    acks.delete();
    req = 4'b0001;
    cyc();
    req = 4'b0010;
    cyc();
    req = '0;
    repeat (4) cyc();
    n1 = 0;
    foreach (acks[i]) if (acks[i] == 1) n1++;
    chk("withdraw", 64'(n1), 64'h0);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      req       = N'($urandom_range(0, 15));
      req_addr  = $urandom;
      rsp_ready = N'($urandom_range(0, 15));
      rst_n     = ($urandom_range(0, 39) != 0);
      cyc();
    end
    rst_n = 1'b1;

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

endmodule
